// File: rtl/tlb_pkg.sv
// tlb_pkg: shared constants and types for the ECO32 TLB key half.
//   ENTRIES / INDEX_WIDTH / KEY_WIDTH : array geometry
//   FIXED_ENTRIES                     : low entries protected from random replacement
//   tlb_op_e                          : management command encodings
//   RAND_RESET / RAND_FLOOR           : random replacement counter range
package tlb_pkg;

  localparam int unsigned ENTRIES       = 32;
  localparam int unsigned INDEX_WIDTH   = 5;
  localparam int unsigned KEY_WIDTH     = 20;
  localparam int unsigned FIXED_ENTRIES = 4;

  typedef enum logic [1:0] {
    OpProbe        = 2'd0,
    OpRead         = 2'd1,
    OpWriteIndexed = 2'd2,
    OpWriteRandom  = 2'd3
  } tlb_op_e;

  localparam logic [INDEX_WIDTH-1:0] RAND_RESET = INDEX_WIDTH'(ENTRIES - 1);
  localparam logic [INDEX_WIDTH-1:0] RAND_FLOOR = INDEX_WIDTH'(FIXED_ENTRIES);

endpackage

// File: rtl/tlb_match_encoder.sv
// tlb_match_encoder: compares one key against every stored entry and priority
// encodes the result, lowest matching index first.
//   i_key         : key to search for
//   i_entries     : all stored keys
//   o_hit         : at least one entry matched
//   o_index       : lowest matching index, 0 on miss
//   o_multi_hit   : two or more entries matched (only with TLB_MULTIHIT_DETECT_EN)
module tlb_match_encoder
  import tlb_pkg::*;
(
  input  logic [KEY_WIDTH-1:0]   i_key,
  input  logic [KEY_WIDTH-1:0]   i_entries [ENTRIES],
`ifdef TLB_MULTIHIT_DETECT_EN
  output logic                   o_multi_hit,
`endif
  output logic                   o_hit,
  output logic [INDEX_WIDTH-1:0] o_index
);

  logic                   w_hit;
  logic [INDEX_WIDTH-1:0] w_index;
  logic                   w_multi;

  // Scan from the top down so the last match seen is the lowest index; a
  // match found while w_hit is already set means a second matching entry.
  always_comb begin
    w_hit   = 1'b0;
    w_index = '0;
    w_multi = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (i_entries[i] == i_key) begin
        w_multi = w_multi | w_hit;
        w_hit   = 1'b1;
        w_index = INDEX_WIDTH'(i);
      end
    end
  end

  assign o_hit   = w_hit;
  assign o_index = w_index;

`ifdef TLB_MULTIHIT_DETECT_EN
  assign o_multi_hit = w_multi;
`else
  logic w_multi_unused;
  assign w_multi_unused = w_multi;
`endif

endmodule

// File: rtl/tlb_key_lookup.sv
// tlb_key_lookup: associative key half of the ECO32 TLB.
// Holds ENTRIES virtual page numbers, answers translation lookups with a
// registered hit/index, and executes PROBE / READ / WRITE_INDEXED /
// WRITE_RANDOM while driving the value memory's second port.
// Optional feature macro: TLB_MULTIHIT_DETECT_EN adds o_lookup_multi_hit.
//   i_clock, i_reset (sync, active low)
//   i_lookup_valid/i_lookup_page -> o_lookup_done/o_lookup_hit/o_lookup_index
//   i_cmd_valid/o_cmd_ready/i_cmd_op/i_cmd_index/i_cmd_key
//     -> o_cmd_done/o_cmd_hit/o_cmd_result_index/o_cmd_read_key
//   o_value_index/o_value_write_enable : value memory port 2 (combinational)
module tlb_key_lookup
  import tlb_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_lookup_valid,
  input  logic [KEY_WIDTH-1:0]   i_lookup_page,
  output logic                   o_lookup_done,
  output logic                   o_lookup_hit,
  output logic [INDEX_WIDTH-1:0] o_lookup_index,
`ifdef TLB_MULTIHIT_DETECT_EN
  output logic                   o_lookup_multi_hit,
`endif
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic [INDEX_WIDTH-1:0] i_cmd_index,
  input  logic [KEY_WIDTH-1:0]   i_cmd_key,
  output logic                   o_cmd_done,
  output logic                   o_cmd_hit,
  output logic [INDEX_WIDTH-1:0] o_cmd_result_index,
  output logic [KEY_WIDTH-1:0]   o_cmd_read_key,
  output logic [INDEX_WIDTH-1:0] o_value_index,
  output logic                   o_value_write_enable
);

  logic [KEY_WIDTH-1:0]   r_keys [ENTRIES];
  logic [INDEX_WIDTH-1:0] r_random;

  logic                   r_lookup_done;
  logic                   r_lookup_hit;
  logic [INDEX_WIDTH-1:0] r_lookup_index;
  logic                   r_cmd_done;
  logic                   r_cmd_hit;
  logic [INDEX_WIDTH-1:0] r_cmd_result_index;
  logic [KEY_WIDTH-1:0]   r_cmd_read_key;

  tlb_op_e                w_op;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_is_write;
  logic [INDEX_WIDTH-1:0] w_cmd_slot;
  logic [INDEX_WIDTH-1:0] w_value_index;
  logic                   w_value_we;
  logic [KEY_WIDTH-1:0]   w_match_key;
  logic                   w_enc_hit;
  logic [INDEX_WIDTH-1:0] w_enc_index;

  assign w_op       = tlb_op_e'(i_cmd_op);
  // Lookups own the comparator bank, so commands stall while one is offered.
  assign w_ready    = i_reset & ~i_lookup_valid;
  assign w_accept   = i_cmd_valid & w_ready;
  assign w_is_write = (w_op == OpWriteIndexed) || (w_op == OpWriteRandom);
  assign w_cmd_slot = (w_op == OpWriteRandom) ? r_random : i_cmd_index;

  always_comb begin
    w_value_index = '0;
    w_value_we    = 1'b0;
    if (w_accept) begin
      w_value_index = w_cmd_slot;
      w_value_we    = w_is_write;
    end
  end

  assign w_match_key = i_lookup_valid ? i_lookup_page : i_cmd_key;

`ifdef TLB_MULTIHIT_DETECT_EN
  logic w_enc_multi;
  logic r_multi_hit;

  tlb_match_encoder u_match (
    .i_key       (w_match_key),
    .i_entries   (r_keys),
    .o_multi_hit (w_enc_multi),
    .o_hit       (w_enc_hit),
    .o_index     (w_enc_index)
  );

  // Shared flag: follows whichever search (lookup or PROBE) completed last.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_multi_hit <= 1'b0;
    end else if (i_lookup_valid || (w_accept && (w_op == OpProbe))) begin
      r_multi_hit <= w_enc_multi;
    end
  end

  assign o_lookup_multi_hit = r_multi_hit;
`else
  tlb_match_encoder u_match (
    .i_key     (w_match_key),
    .i_entries (r_keys),
    .o_hit     (w_enc_hit),
    .o_index   (w_enc_index)
  );
`endif

  // Key storage is deliberately not reset; w_value_we is already 0 in reset.
  always_ff @(posedge i_clock) begin
    if (w_value_we) begin
      r_keys[w_value_index] <= i_cmd_key;
    end
  end

  // Free-running replacement pointer, cycling RAND_RESET down to RAND_FLOOR.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_random <= RAND_RESET;
    end else if (r_random == RAND_FLOOR) begin
      r_random <= RAND_RESET;
    end else begin
      r_random <= r_random - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_lookup_done  <= 1'b0;
      r_lookup_hit   <= 1'b0;
      r_lookup_index <= '0;
    end else begin
      r_lookup_done <= i_lookup_valid;
      if (i_lookup_valid) begin
        r_lookup_hit   <= w_enc_hit;
        r_lookup_index <= w_enc_index;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_cmd_done         <= 1'b0;
      r_cmd_hit          <= 1'b0;
      r_cmd_result_index <= '0;
      r_cmd_read_key     <= '0;
    end else begin
      r_cmd_done <= w_accept;
      if (w_accept) begin
        // cmd_hit only carries meaning for PROBE; other ops clear it.
        r_cmd_hit <= (w_op == OpProbe) ? w_enc_hit : 1'b0;
        r_cmd_result_index <= (w_op == OpProbe) ? w_enc_index : w_cmd_slot;
        if (w_op == OpRead) begin
          r_cmd_read_key <= r_keys[i_cmd_index];
        end
      end
    end
  end

  assign o_lookup_done        = r_lookup_done;
  assign o_lookup_hit         = r_lookup_hit;
  assign o_lookup_index       = r_lookup_index;
  assign o_cmd_ready          = w_ready;
  assign o_cmd_done           = r_cmd_done;
  assign o_cmd_hit            = r_cmd_hit;
  assign o_cmd_result_index   = r_cmd_result_index;
  assign o_cmd_read_key       = r_cmd_read_key;
  assign o_value_index        = w_value_index;
  assign o_value_write_enable = w_value_we;

endmodule

// File: tb/tb_tlb_key_lookup.sv
// Self-checking bench for tlb_key_lookup: directed scenarios followed by
// randomized traffic scored against an array model of the key store.
module tb_tlb_key_lookup;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [19:0] lookup_page;
  logic        lookup_done;
  logic        lookup_hit;
  logic [4:0]  lookup_index;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_index;
  logic [19:0] cmd_key;
  logic        cmd_done;
  logic        cmd_hit;
  logic [4:0]  cmd_result_index;
  logic [19:0] cmd_read_key;
  logic [4:0]  value_index;
  logic        value_we;
`ifdef TLB_MULTIHIT_DETECT_EN
  logic        multi_hit;
`endif

  tlb_key_lookup dut (
    .i_clock              (clk),
    .i_reset              (rst),
    .i_lookup_valid       (lookup_valid),
    .i_lookup_page        (lookup_page),
    .o_lookup_done        (lookup_done),
    .o_lookup_hit         (lookup_hit),
    .o_lookup_index       (lookup_index),
`ifdef TLB_MULTIHIT_DETECT_EN
    .o_lookup_multi_hit   (multi_hit),
`endif
    .i_cmd_valid          (cmd_valid),
    .o_cmd_ready          (cmd_ready),
    .i_cmd_op             (cmd_op),
    .i_cmd_index          (cmd_index),
    .i_cmd_key            (cmd_key),
    .o_cmd_done           (cmd_done),
    .o_cmd_hit            (cmd_hit),
    .o_cmd_result_index   (cmd_result_index),
    .o_cmd_read_key       (cmd_read_key),
    .o_value_index        (value_index),
    .o_value_write_enable (value_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int n_since = 0;  // rising edges with reset high since the last reset edge

  logic [19:0] model_keys [32];

  always @(posedge clk) begin
    if (!rst) n_since <= 0;
    else      n_since <= n_since + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Replacement pointer walks 31,30,...,4 and repeats: period 28.
  function automatic logic [4:0] model_rand();
    return 5'(31 - (n_since % 28));
  endfunction

  task automatic model_search(input logic [19:0] k, output logic hit, output logic [4:0] idx,
                              output logic multi);
    int cnt;
    cnt = 0;
    hit = 1'b0;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (model_keys[i] == k) begin
        if (cnt == 0) idx = 5'(i);
        cnt++;
      end
    end
    hit   = (cnt > 0);
    multi = (cnt > 1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] idx, input logic [19:0] key,
                        output logic [4:0] obs_vi);
    logic [4:0]  exp_idx;
    logic        e_hit;
    logic [4:0]  e_idx;
    logic        e_multi;
    logic [19:0] e_rkey;
    exp_idx = (op == 2'd3) ? model_rand() : idx;
    model_search(key, e_hit, e_idx, e_multi);
    e_rkey = model_keys[idx];
    lookup_valid = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_index = idx;
    cmd_key   = key;
    #1;
    obs_vi = value_index;
    check_eq("cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("value_index", 32'(value_index), 32'(exp_idx));
    check_eq("value_we", 32'(value_we), 32'(op[1]));
    tick();
    cmd_valid = 1'b0;
    if (op[1]) model_keys[exp_idx] = key;
    check_eq("cmd_done", 32'(cmd_done), 32'd1);
    if (op == 2'd0) begin
      check_eq("probe_hit", 32'(cmd_hit), 32'(e_hit));
      check_eq("probe_index", 32'(cmd_result_index), 32'(e_idx));
`ifdef TLB_MULTIHIT_DETECT_EN
      check_eq("probe_multi", 32'(multi_hit), 32'(e_multi));
`endif
    end else begin
      check_eq("cmd_result_index", 32'(cmd_result_index), 32'(exp_idx));
      if (op == 2'd1) check_eq("read_key", 32'(cmd_read_key), 32'(e_rkey));
    end
  endtask

  task automatic do_lookup(input logic [19:0] page);
    logic       e_hit;
    logic [4:0] e_idx;
    logic       e_multi;
    model_search(page, e_hit, e_idx, e_multi);
    lookup_valid = 1'b1;
    lookup_page  = page;
    tick();
    lookup_valid = 1'b0;
    check_eq("lookup_done", 32'(lookup_done), 32'd1);
    check_eq("lookup_hit", 32'(lookup_hit), 32'(e_hit));
    check_eq("lookup_index", 32'(lookup_index), 32'(e_idx));
`ifdef TLB_MULTIHIT_DETECT_EN
    check_eq("lookup_multi", 32'(multi_hit), 32'(e_multi));
`endif
  endtask

  task automatic idle_check();
    tick();
    check_eq("idle_lookup_done", 32'(lookup_done), 32'd0);
    check_eq("idle_cmd_done", 32'(cmd_done), 32'd0);
  endtask

  initial begin
    logic [4:0]  vi;
    logic [19:0] k;
    int          sel;
    rst = 1'b0;
    lookup_valid = 1'b1;
    lookup_page  = 20'h0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_index = 5'd0;
    cmd_key   = 20'h0;
    for (int i = 0; i < 32; i++) model_keys[i] = 20'hxxxxx;
    repeat (3) tick();

    // Reset state, with requests offered during reset.
    lookup_valid = 1'b0;
    #1;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_value_we", 32'(value_we), 32'd0);
    check_eq("rst_lookup_done", 32'(lookup_done), 32'd0);
    check_eq("rst_lookup_hit", 32'(lookup_hit), 32'd0);
    check_eq("rst_lookup_index", 32'(lookup_index), 32'd0);
    check_eq("rst_cmd_done", 32'(cmd_done), 32'd0);
    check_eq("rst_cmd_hit", 32'(cmd_hit), 32'd0);
    check_eq("rst_cmd_result_index", 32'(cmd_result_index), 32'd0);
    check_eq("rst_cmd_read_key", 32'(cmd_read_key), 32'd0);
    cmd_valid = 1'b0;
    rst = 1'b1;

    // Replacement pointer: 4 at 27 cycles after release, wraps to 31 at 28.
    repeat (27) idle_check();
    do_cmd(2'd3, 5'd0, 20'h11111, vi);
    check_eq("rand_at_27", 32'(vi), 32'd4);
    do_cmd(2'd3, 5'd0, 20'h22222, vi);
    check_eq("rand_wrap_31", 32'(vi), 32'd31);

    // Fill every entry with a distinct key so the model is fully defined.
    for (int i = 0; i < 32; i++) do_cmd(2'd2, 5'(i), 20'hF0000 | 20'(i), vi);

    // Indexed write then lookup; result held after the done pulse.
    do_cmd(2'd2, 5'd3, 20'h12345, vi);
    do_lookup(20'h12345);
    check_eq("dir_hit3", 32'(lookup_index), 32'd3);
    idle_check();
    check_eq("held_hit", 32'(lookup_hit), 32'd1);
    check_eq("held_index", 32'(lookup_index), 32'd3);

    // Miss.
    do_lookup(20'h54321);
    check_eq("dir_miss", 32'(lookup_hit), 32'd0);
    idle_check();

    // Duplicate keys: PROBE returns the lower index.
    do_cmd(2'd2, 5'd5, 20'h00AAA, vi);
    do_cmd(2'd2, 5'd9, 20'h00AAA, vi);
    do_cmd(2'd0, 5'd0, 20'h00AAA, vi);
    check_eq("dir_probe_idx5", 32'(cmd_result_index), 32'd5);
    do_cmd(2'd0, 5'd0, 20'h77777, vi);
    check_eq("dir_probe_miss_idx", 32'(cmd_result_index), 32'd0);

    // Lookup and command together: command stalls one cycle.
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    cmd_index = 5'd12;
    cmd_key   = 20'h0CAFE;
    lookup_valid = 1'b1;
    lookup_page  = 20'h12345;
    #1;
    check_eq("arb_ready", 32'(cmd_ready), 32'd0);
    check_eq("arb_we", 32'(value_we), 32'd0);
    do_lookup(20'h12345);
    check_eq("arb_no_cmd_done", 32'(cmd_done), 32'd0);
    do_cmd(2'd2, 5'd12, 20'h0CAFE, vi);
    do_lookup(20'h0CAFE);

    // Write in N, lookup in N+1 sees it; READ returns it.
    do_cmd(2'd2, 5'd7, 20'h0BEEF, vi);
    do_lookup(20'h0BEEF);
    do_cmd(2'd1, 5'd7, 20'h0, vi);
    check_eq("dir_read_beef", 32'(cmd_read_key), 32'h0BEEF);

    // Reset in the same cycle as a request discards it.
    lookup_valid = 1'b1;
    lookup_page  = 20'h0BEEF;
    rst = 1'b0;
    tick();
    lookup_valid = 1'b0;
    check_eq("midrst_lookup_done", 32'(lookup_done), 32'd0);
    check_eq("midrst_lookup_hit", 32'(lookup_hit), 32'd0);
    rst = 1'b1;
    do_lookup(20'h0BEEF);

    // 200 random writes, never landing in the fixed entries.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle_check();
      do_cmd(2'd3, 5'd0, 20'hA0000 | 20'($urandom_range(0, 15)), vi);
      check_eq("rand_not_fixed", 32'(vi >= 5'd4), 32'd1);
    end

    // Mixed randomized traffic.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 0) k = model_keys[$urandom_range(0, 31)];
      else k = 20'hA0000 | 20'($urandom_range(0, 31));
      case (sel)
        0: do_lookup(k);
        1: do_cmd(2'd0, 5'd0, k, vi);
        2: do_cmd(2'd1, 5'($urandom_range(0, 31)), 20'h0, vi);
        3: do_cmd(2'($urandom_range(2, 3)), 5'($urandom_range(0, 31)),
                  20'hA0000 | 20'($urandom_range(0, 31)), vi);
        4: begin
          cmd_valid = 1'b1;
          cmd_op    = 2'd2;
          cmd_index = 5'($urandom_range(0, 31));
          cmd_key   = k;
          lookup_valid = 1'b1;
          lookup_page  = k;
          #1;
          check_eq("rnd_arb_ready", 32'(cmd_ready), 32'd0);
          check_eq("rnd_arb_we", 32'(value_we), 32'd0);
          do_lookup(k);
          check_eq("rnd_arb_no_done", 32'(cmd_done), 32'd0);
          do_cmd(2'd2, cmd_index, k, vi);
        end
        default: idle_check();
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
